// File: rtl/gray_bcd_scan_display.sv
// gray_bcd_scan_display
//
// Time-multiplexed multi-digit 7-segment driver. A packed vector of DIGITS
// 4-bit codes (Gray or plain BCD, chosen by GRAY_IN) is captured into a
// shadow register on load, then scanned one digit at a time onto a shared
// segment bus with one-hot active-low digit enables.
//
// Parameters
//   DIGITS   : number of display digits (1..8)
//   SCAN_DIV : clocks each digit stays enabled (>= 2)
//   GRAY_IN  : 1 = codes are Gray-coded, 0 = plain BCD
//
// Ports
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset
//   load   : capture din into the shadow register
//   din    : packed digit codes, digit 0 in din[3:0]
//   n_T    : lamp test, active low (all segments lit)
//   n_M    : blank, active low (all segments dark)
//   lz_en  : suppress leading zeros
//   seg    : registered segments {a,b,c,d,e,f,g}, active high
//   dig_n  : registered one-hot active-low digit enables
//   err    : sticky flag, an invalid code was loaded
//   tick   : one-cycle pulse when the scan index wraps to digit 0
module gray_bcd_scan_display #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int GRAY_IN  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    input  logic                  n_T,
    input  logic                  n_M,
    input  logic                  lz_en,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_n,
    output logic                  err,
    output logic                  tick
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PC_W  = $clog2(SCAN_DIV);
    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Returns {valid, value}. Invalid codes return all zeros.
    function automatic logic [4:0] decode_code(input logic [3:0] code);
        logic [4:0] r;
        r = 5'b0;
        if (GRAY_IN != 0) begin
            case (code)
                4'b0000: r = {1'b1, 4'd0};
                4'b0001: r = {1'b1, 4'd1};
                4'b0011: r = {1'b1, 4'd2};
                4'b0010: r = {1'b1, 4'd3};
                4'b0110: r = {1'b1, 4'd4};
                4'b0111: r = {1'b1, 4'd5};
                4'b0101: r = {1'b1, 4'd6};
                4'b0100: r = {1'b1, 4'd7};
                4'b1100: r = {1'b1, 4'd8};
                4'b1000: r = {1'b1, 4'd9};
                default: r = 5'b0;
            endcase
        end else if (code <= 4'd9) begin
            r = {1'b1, code};
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b111_1110;
            4'd1:    s = 7'b011_0000;
            4'd2:    s = 7'b110_1101;
            4'd3:    s = 7'b111_1001;
            4'd4:    s = 7'b011_0011;
            4'd5:    s = 7'b101_1011;
            4'd6:    s = 7'b101_1111;
            4'd7:    s = 7'b111_0000;
            4'd8:    s = 7'b111_1111;
            4'd9:    s = 7'b111_1011;
            default: s = 7'b000_0000;
        endcase
        return s;
    endfunction

    logic [PC_W-1:0]     pc_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [4*DIGITS-1:0] shadow_reg;

    logic [6:0]          digit_seg  [DIGITS];
    logic [DIGITS-1:0]   digit_zero;
    logic [DIGITS-1:0]   din_bad;
    logic [DIGITS-1:0]   suppress;
    logic [DIGITS-1:0]   dig_next;
    logic [6:0]          seg_next;
    logic                pc_wrap;

    // Per-digit decode of the shadow contents and validity check of din.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [4:0] shadow_dec;
        logic [4:0] din_dec;
        assign shadow_dec     = decode_code(shadow_reg[4*gi +: 4]);
        assign din_dec        = decode_code(din[4*gi +: 4]);
        assign digit_seg[gi]  = shadow_dec[4] ? seg_of(shadow_dec[3:0]) : 7'b000_0000;
        assign digit_zero[gi] = shadow_dec[4] && (shadow_dec[3:0] == 4'd0);
        assign din_bad[gi]    = !din_dec[4];
        assign dig_next[gi]   = (idx_reg != IDX_W'(gi));
    end

    // Leading-zero run scanned from the most significant digit down; an
    // invalid code is not "zero" and therefore ends the run.
    always_comb begin
        logic run;
        run      = 1'b1;
        suppress = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            run         = run & digit_zero[k];
            suppress[k] = lz_en && (k != 0) && run;
        end
    end

    always_comb begin
        seg_next = 7'b000_0000;
        if (!n_T) begin
            seg_next = 7'b111_1111;
        end else if (!n_M) begin
            seg_next = 7'b000_0000;
        end else if (suppress[idx_reg]) begin
            seg_next = 7'b000_0000;
        end else begin
            seg_next = digit_seg[idx_reg];
        end
    end

    assign pc_wrap = (pc_reg == PC_LAST);
    // Combinational so the pulse lines up with the cycle the index wraps.
    assign tick    = !rst && pc_wrap && (idx_reg == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg     <= '0;
            idx_reg    <= '0;
            shadow_reg <= '0;
            seg        <= 7'b000_0000;
            dig_n      <= '1;
            err        <= 1'b0;
        end else begin
            if (pc_wrap) begin
                pc_reg  <= '0;
                idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            end else begin
                pc_reg  <= pc_reg + 1'b1;
            end
            if (load) begin
                shadow_reg <= din;
                if (|din_bad) begin
                    err <= 1'b1;
                end
            end
            seg   <= seg_next;
            dig_n <= dig_next;
        end
    end

endmodule
